// File: rtl/cam_frame_writer_pkg.sv
// Image geometry and pixel widths shared by the camera capture, color processing
// and centroid blocks.
package cam_frame_writer_pkg;

  localparam int C_IMG_COLS    = 160;  // pixels per line
  localparam int C_IMG_ROWS    = 120;  // lines per frame
  localparam int C_NB_IMG_PXLS = 15;   // frame buffer address width
  localparam int C_NB_BUF      = 12;   // RGB444 pixel width

endpackage

// File: rtl/cam_frame_writer.sv
// Packs camera byte pairs into RGB444 pixels and writes them into the frame buffer.
// Latency: 1 cycle from the accepting edge of a pixel's 2nd byte to wea; frame pulses 1 cycle after vsync rises.
// No backpressure: the camera free-runs, so surplus pixels are dropped and flagged rather than stalled.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int c_img_cols    = C_IMG_COLS,
  parameter int c_img_rows    = C_IMG_ROWS,
  parameter int c_nb_img_pxls = C_NB_IMG_PXLS,
  parameter int c_nb_buf      = C_NB_BUF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic                     cam_byte_vld,
  input  logic [7:0]               cam_byte,
  output logic                     wea,
  output logic [c_nb_img_pxls-1:0] addrin,
  output logic [c_nb_buf-1:0]      datain,
  output logic                     capture_newframe,
  output logic                     frame_err
);

  typedef enum logic [1:0] {S_WAIT, S_VBLANK, S_FRAME} state_t;

  localparam int CW = $clog2(c_img_cols + 1);
  localparam int RW = $clog2(c_img_rows + 1);
  localparam logic [CW-1:0]            COLS_C    = CW'(c_img_cols);
  localparam logic [RW-1:0]            ROWS_C    = RW'(c_img_rows);
  localparam logic [c_nb_img_pxls-1:0] LINE_STEP = c_nb_img_pxls'(c_img_cols);

  state_t                   state, state_nxt;
  logic                     href_d;
  logic                     phase, phase_nxt;
  logic                     overflow, overflow_nxt;
  logic                     dangling, dangling_nxt;
  logic [3:0]               red, red_nxt;
  logic [CW-1:0]            col, col_nxt;
  logic [RW-1:0]            row, row_nxt;
  logic [c_nb_img_pxls-1:0] line_base, line_base_nxt;
  logic                     wr_nxt;
  logic                     accept, href_fall, frame_end, frame_ok;

  assign accept    = (state == S_FRAME) & cam_href & cam_byte_vld;
  assign href_fall = href_d & ~cam_href;
  assign frame_end = (state == S_FRAME) & cam_vsync;
  // Uses post-line-accounting values so an href fall coinciding with vsync still counts
  assign frame_ok  = (row_nxt == ROWS_C) & ~overflow_nxt & ~dangling_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (cam_vsync)  state_nxt = S_VBLANK;
      S_VBLANK: if (!cam_vsync) state_nxt = S_FRAME;
      S_FRAME:  if (cam_vsync)  state_nxt = S_VBLANK;
      default:                  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    col_nxt       = col;
    row_nxt       = row;
    line_base_nxt = line_base;
    phase_nxt     = phase;
    red_nxt       = red;
    overflow_nxt  = overflow;
    dangling_nxt  = dangling;
    wr_nxt        = 1'b0;
    if (state != S_FRAME) begin
      col_nxt       = '0;
      row_nxt       = '0;
      line_base_nxt = '0;
      phase_nxt     = 1'b0;
      overflow_nxt  = 1'b0;
      dangling_nxt  = 1'b0;
    end else begin
      if (accept) begin
        if (!phase) begin
          red_nxt   = cam_byte[3:0];
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (col < COLS_C && row < ROWS_C) wr_nxt = 1'b1;
          else                              overflow_nxt = 1'b1;
          // Parks one past the last column so every later pixel stays out of range
          if (col < COLS_C) col_nxt = col + 1'b1;
        end
      end
      if (href_fall) begin
        if (phase) begin
          dangling_nxt = 1'b1;
          phase_nxt    = 1'b0;
        end
        if (col != '0) begin
          col_nxt = '0;
          if (row < ROWS_C) begin
            row_nxt       = row + 1'b1;
            line_base_nxt = line_base + LINE_STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      href_d           <= 1'b0;
      col              <= '0;
      row              <= '0;
      line_base        <= '0;
      phase            <= 1'b0;
      red              <= '0;
      overflow         <= 1'b0;
      dangling         <= 1'b0;
      wea              <= 1'b0;
      addrin           <= '0;
      datain           <= '0;
      capture_newframe <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      href_d           <= cam_href;
      col              <= col_nxt;
      row              <= row_nxt;
      line_base        <= line_base_nxt;
      phase            <= phase_nxt;
      red              <= red_nxt;
      overflow         <= overflow_nxt;
      dangling         <= dangling_nxt;
      wea              <= wr_nxt;
      if (wr_nxt) begin
        addrin <= line_base + c_nb_img_pxls'(col);
        datain <= c_nb_buf'({red, cam_byte});
      end
      capture_newframe <= frame_end & frame_ok;
      frame_err        <= frame_end & ~frame_ok;
    end
  end

endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter c_img_cols, default 160, pixels per line.
REQ-002 SHALL have parameter c_img_rows, default 120, lines per frame.
REQ-003 SHALL have parameter c_nb_img_pxls, default 15, frame buffer address width.
REQ-004 SHALL have parameter c_nb_buf, default 12, pixel width (RGB444).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port cam_vsync, input, 1, camera vertical sync (high = blanking), synchronous to clk.
REQ-008 SHALL have port cam_href, input, 1, camera line-valid, synchronous to clk.
REQ-009 SHALL have port cam_byte_vld, input, 1, one-cycle strobe qualifying cam_byte.
REQ-010 SHALL have port cam_byte, input, 8, camera data byte.
REQ-011 SHALL have port wea, output, 1, frame buffer write enable.
REQ-012 SHALL have port addrin, output, c_nb_img_pxls, frame buffer write address.
REQ-013 SHALL have port datain, output, c_nb_buf, frame buffer write pixel {R,G,B}.
REQ-014 SHALL have port capture_newframe, output, 1, one-cycle pulse after a complete frame is written.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse after an incomplete or oversized frame.

Function
REQ-016 SHALL use states S_WAIT (discard until first cam_vsync=1), S_VBLANK (cam_vsync=1, counters cleared) and S_FRAME (cam_vsync=0, capturing).
REQ-017 SHALL transition S_WAIT->S_VBLANK on cam_vsync=1, S_VBLANK->S_FRAME on cam_vsync=0, and S_FRAME->S_VBLANK on cam_vsync=1.
REQ-018 SHALL accept a byte only in S_FRAME when cam_href=1 and cam_byte_vld=1.
REQ-019 SHALL treat the 1st accepted byte of a pixel as xxxxRRRR (keep bits 3:0) and the 2nd as GGGGBBBB.
REQ-020 SHALL, on the 2nd byte, drive wea=1 for exactly one cycle on the next clock, with datain={R,cam_byte} and addrin=line_base+col, where latency is 1 cycle from the accepting edge.
REQ-021 SHALL compute line_base by adding c_img_cols per completed line; no multiplier.
REQ-022 SHALL increment col after each write, and increment row, add to line_base and clear col on cam_href falling edge when col>0.
REQ-023 SHALL discard a dangling 1st byte on cam_href falling edge and reset the byte phase to 1st.
REQ-024 SHALL suppress writes (wea=0) and flag overflow for pixels with col>=c_img_cols or row>=c_img_rows.
REQ-025 SHALL, on S_FRAME->S_VBLANK, pulse capture_newframe the following cycle iff row==c_img_rows, no overflow occurred and no dangling byte was discarded; otherwise pulse frame_err instead.
REQ-026 SHALL never assert capture_newframe and frame_err in the same cycle, and SHALL assert neither on leaving S_WAIT.
REQ-027 SHALL, when cam_href falls and cam_vsync rises in the same cycle, complete the line accounting before the frame check.
REQ-028 SHALL register all outputs; addrin and datain hold their last values when wea=0.

Reset
REQ-029 SHALL, on rst=1, enter S_WAIT and clear col, row, line_base, byte phase and overflow flag, and drive wea=0, addrin=0, datain=0, capture_newframe=0 and frame_err=0 on the next edge.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame silently and resume only after the next cam_vsync=1.

Structure
REQ-031 SHALL take the image size and bit-width constants (160, 120, 15, 12) from the shared design package used by the color processing and centroid blocks.
REQ-032 SHALL hold the state encoding as a local typedef, since no other block uses it.
REQ-033 SHALL be implemented as one module with no sub-modules; edge detectors are inline registers.

Verification
REQ-034 SHALL verify: full 160x120 frame, byte pairs 0x0A,0xBC, then vsync rise -> 19200 writes, datain=0xABC, last addrin=19199, one capture_newframe pulse.
REQ-035 SHALL verify: line 0 pixel 5 bytes 0x03,0x45 -> wea with addrin=5 and datain=0x345 one cycle after the 2nd byte.
REQ-036 SHALL verify: line with 161 pixels -> 160 writes, 161st suppressed, frame_err pulses at frame end and capture_newframe does not.
REQ-037 SHALL verify: href falls after an odd byte on line 3 -> no write for that byte, next line starts at addrin=640, frame_err at frame end.
REQ-038 SHALL verify: vsync rises after 60 lines -> frame_err pulse, counters cleared, next full frame starts at addrin=0.
REQ-039 SHALL verify: rst at row 50 -> outputs zero the next cycle, no writes until vsync=1 then 0, no pulse at the end of the aborted frame.
